// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RISC-V style datapath: sequences fetch, decode, execute,
// memory and write-back, and counts retired instructions.
module multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic [1:0]  MemtoReg,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic        illegal,
    output logic [31:0] instret
);

    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpIType = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StFault  = 3'd5
    } state_e;

    state_e      r_state;
    state_e      w_next;
    logic [6:0]  r_op;
    logic [31:0] r_instret;
    logic        r_illegal;
    logic        w_legal;
    logic        w_done;
    logic        w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br, w_is_jal, w_is_jalr;

    // Legality is judged on the live opcode in DECODE; EXEC onward uses the latched copy.
    assign w_legal = (opcode == OpRType) || (opcode == OpIType) || (opcode == OpLoad) ||
                     (opcode == OpStore) || (opcode == OpBr) || (opcode == OpJal) ||
                     (opcode == OpJalr);

    assign w_is_r    = (r_op == OpRType);
    assign w_is_i    = (r_op == OpIType);
    assign w_is_ld   = (r_op == OpLoad);
    assign w_is_st   = (r_op == OpStore);
    assign w_is_br   = (r_op == OpBr);
    assign w_is_jal  = (r_op == OpJal);
    assign w_is_jalr = (r_op == OpJalr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            StFetch:  w_next = mem_ready ? StDecode : StFetch;
            StDecode: w_next = w_legal ? StExec : StFault;
            StExec: begin
                if (w_is_r || w_is_i) begin
                    w_next = StWb;
                end else if (w_is_ld || w_is_st) begin
                    w_next = StMem;
                end else begin
                    w_next = StFetch;
                end
            end
            StMem: begin
                if (mem_ready) begin
                    w_next = w_is_ld ? StWb : StFetch;
                end
            end
            StWb:     w_next = StFetch;
            StFault:  w_next = StFault;
            default:  w_next = StFault;
        endcase
    end

    // Retire in the last cycle of any instruction; FETCH stalls and FAULT never retire.
    assign w_done = (r_state != StFetch) && (r_state != StFault) && (w_next == StFetch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= 7'd0;
            r_instret <= 32'd0;
            r_illegal <= 1'b0;
        end else begin
            if (r_state == StDecode) begin
                r_op <= opcode;
            end
            if (w_done) begin
                r_instret <= r_instret + 32'd1;
            end
            if (w_next == StFault) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        MemtoReg    = 2'b00;
        case (r_state)
            StFetch: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            StDecode: begin
                ALUSrcB = 2'b10;
            end
            StExec: begin
                if (w_is_r) begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end else if (w_is_i) begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = 2'b10;
                end else if (w_is_ld || w_is_st) begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end else if (w_is_br) begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end else if (w_is_jal) begin
                    // Link and PC update share one edge so the link captures PC+4.
                    PCWrite  = 1'b1;
                    PCSource = 2'b01;
                    RegWrite = 1'b1;
                    MemtoReg = 2'b10;
                end else if (w_is_jalr) begin
                    ALUSrcA  = 1'b1;
                    ALUSrcB  = 2'b10;
                    PCWrite  = 1'b1;
                    RegWrite = 1'b1;
                    MemtoReg = 2'b10;
                end
            end
            StMem: begin
                IorD     = 1'b1;
                MemRead  = w_is_ld;
                MemWrite = w_is_st;
            end
            StWb: begin
                RegWrite = 1'b1;
                MemtoReg = w_is_ld ? 2'b01 : 2'b00;
            end
            default: ;
        endcase
    end

    assign state      = r_state;
    assign instr_done = w_done;
    assign illegal    = r_illegal;
    assign instret    = r_instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction phase sequences are built from the
// instruction-class rules and every cycle's outputs are compared against a lookup model.
module tb_multicycle_control;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource, MemtoReg;
    logic [2:0]  state;
    logic        instr_done, illegal;
    logic [31:0] instret;

    multicycle_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSource   (PCSource),
        .MemtoReg   (MemtoReg),
        .state      (state),
        .instr_done (instr_done),
        .illegal    (illegal),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {KR, KI, KLD, KST, KBR, KJAL, KJALR} kind_e;
    typedef enum int {PF, PD, PE, PM, PW, PX} phase_e;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, rgw, asa;
        logic [1:0] asb, aop, pcs, m2r;
        logic [2:0] st;
        logic       done, ill;
    } ctl_t;

    int          n_chk = 0;
    int          n_fail = 0;
    logic        exp_valid = 1'b0;
    ctl_t        exp_c;
    logic [31:0] m_instret = 32'd0;
    logic [2:0]  st_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    function automatic logic [6:0] op_of(input kind_e k);
        case (k)
            KR:      return 7'b0110011;
            KI:      return 7'b0010011;
            KLD:     return 7'b0000011;
            KST:     return 7'b0100011;
            KBR:     return 7'b1100011;
            KJAL:    return 7'b1101111;
            default: return 7'b1100111;
        endcase
    endfunction

    // Output table straight from the per-phase, per-class rules.
    function automatic ctl_t exp_of(input phase_e ph, input kind_e k, input logic mr);
        ctl_t c;
        c = '0;
        case (ph)
            PF: begin
                c.st = 3'd0; c.mrd = 1'b1; c.asb = 2'b01; c.irw = mr; c.pcw = mr;
            end
            PD: begin
                c.st = 3'd1; c.asb = 2'b10;
            end
            PE: begin
                c.st = 3'd2;
                case (k)
                    KR:  begin c.asa = 1'b1; c.aop = 2'b10; end
                    KI:  begin c.asa = 1'b1; c.asb = 2'b10; c.aop = 2'b10; end
                    KLD, KST: begin c.asa = 1'b1; c.asb = 2'b10; end
                    KBR: begin
                        c.asa = 1'b1; c.aop = 2'b01; c.pcwc = 1'b1; c.pcs = 2'b01; c.done = 1'b1;
                    end
                    KJAL: begin
                        c.pcw = 1'b1; c.pcs = 2'b01; c.rgw = 1'b1; c.m2r = 2'b10; c.done = 1'b1;
                    end
                    default: begin
                        c.asa = 1'b1; c.asb = 2'b10; c.pcw = 1'b1; c.rgw = 1'b1;
                        c.m2r = 2'b10; c.done = 1'b1;
                    end
                endcase
            end
            PM: begin
                c.st = 3'd3; c.iord = 1'b1;
                if (k == KLD) c.mrd = 1'b1;
                else c.mwr = 1'b1;
                c.done = (k == KST) && mr;
            end
            PW: begin
                c.st = 3'd4; c.rgw = 1'b1; c.m2r = (k == KLD) ? 2'b01 : 2'b00; c.done = 1'b1;
            end
            default: begin
                c.st = 3'd5; c.ill = 1'b1;
            end
        endcase
        return c;
    endfunction

    function automatic logic [31:0] pack_log();
        logic [31:0] v;
        v = 32'd0;
        foreach (st_log[i]) v = {v[27:0], 1'b0, st_log[i]};
        return v;
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            ctl_t act;
            act = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
                    ALUSrcB, ALUOp, PCSource, MemtoReg, state, instr_done, illegal};
            chk("ctl", 64'(act), 64'(exp_c));
            chk("instret", 64'(instret), 64'(m_instret));
            st_log.push_back(state);
        end
    end

    // Drive one cycle from posedge+1 through the next posedge.
    task automatic cycle(input logic [6:0] opc, input logic mr, input ctl_t e);
        opcode    = opc;
        mem_ready = mr;
        exp_c     = e;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
        if (e.done) m_instret = m_instret + 32'd1;
    endtask

    task automatic run_instr(input kind_e k, input int fstall, input int mstall);
        logic r;
        for (int i = 0; i < fstall; i++) cycle(7'($urandom), 1'b0, exp_of(PF, k, 1'b0));
        cycle(7'($urandom), 1'b1, exp_of(PF, k, 1'b1));
        r = 1'($urandom);
        cycle(op_of(k), r, exp_of(PD, k, r));
        r = 1'($urandom);
        cycle(7'($urandom), r, exp_of(PE, k, r));
        if (k == KLD || k == KST) begin
            for (int i = 0; i < mstall; i++) cycle(7'($urandom), 1'b0, exp_of(PM, k, 1'b0));
            cycle(7'($urandom), 1'b1, exp_of(PM, k, 1'b1));
        end
        if (k == KR || k == KI || k == KLD) begin
            r = 1'($urandom);
            cycle(7'($urandom), r, exp_of(PW, k, r));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        opcode    = 7'd0;
        mem_ready = 1'b0;
        #2;
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_instret", 64'(instret), 64'd0);
        chk("reset_illegal", 64'(illegal), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        st_log.delete();
        run_instr(KR, 0, 0);
        chk("rtype_states", 64'(pack_log()), 64'h0124);
        chk("rtype_instret", 64'(instret), 64'd1);

        st_log.delete();
        run_instr(KLD, 0, 2);
        chk("load_states", 64'(pack_log()), 64'h0123334);

        st_log.delete();
        run_instr(KST, 0, 0);
        chk("store_states", 64'(pack_log()), 64'h0123);

        st_log.delete();
        run_instr(KJAL, 0, 0);
        chk("jal_states", 64'(pack_log()), 64'h012);
        chk("jal_instret", 64'(instret), 64'd4);

        for (int n = 0; n < 200; n++) begin
            kind_e k;
            int    fs, ms;
            k  = kind_e'($urandom_range(0, 6));
            fs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            ms = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            run_instr(k, fs, ms);
        end

        // Reset asserted in the middle of a stalled store.
        cycle(7'($urandom), 1'b1, exp_of(PF, KST, 1'b1));
        cycle(op_of(KST), 1'b0, exp_of(PD, KST, 1'b0));
        cycle(7'($urandom), 1'b0, exp_of(PE, KST, 1'b0));
        opcode    = 7'($urandom);
        mem_ready = 1'b0;
        exp_c     = exp_of(PM, KST, 1'b0);
        @(negedge clk);
        #1;
        exp_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("midmem_memwrite", 64'(MemWrite), 64'd0);
        chk("midmem_state", 64'(state), 64'd0);
        chk("midmem_instret", 64'(instret), 64'd0);
        m_instret = 32'd0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        m_instret = 32'hFFFF_FFFF;
        chk("preset_instret", 64'(instret), 64'hFFFF_FFFF);
        run_instr(KJAL, 0, 0);
        chk("wrap_instret", 64'(instret), 64'd0);

        // Illegal opcode: FAULT is sticky regardless of inputs.
        cycle(7'($urandom), 1'b1, exp_of(PF, KR, 1'b1));
        cycle(7'b1111111, 1'b1, exp_of(PD, KR, 1'b1));
        for (int i = 0; i < 10; i++) cycle(7'($urandom), 1'($urandom), exp_of(PX, KR, 1'b0));
        exp_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("fault_reset_state", 64'(state), 64'd0);
        chk("fault_reset_illegal", 64'(illegal), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
